// File: rtl/bsg_down_pkg.sv
// Shared types for the downstream channel: widths, pointer/entry types, pack FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package bsg_down_pkg;

  localparam int BYTE_W  = 8;
  localparam int ENTRY_W = 2 * BYTE_W;
  localparam int ADDR_W  = 6;
  localparam int PTR_W   = ADDR_W + 1;

  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [ENTRY_W-1:0] entry_t;

  typedef enum logic {
    LO = 1'b0,
    HI = 1'b1
  } pack_state_e;

  // Equal low bits with differing wrap bits means the writer is a full lap ahead.
  function automatic logic ptr_full(ptr_t w, ptr_t r);
    return (w[ADDR_W-1:0] == r[ADDR_W-1:0]) && (w[ADDR_W] != r[ADDR_W]);
  endfunction

endpackage

// File: rtl/bsg_down_token_gen.sv
// Credit return: one-cycle pulse per DECIMATE entries drained; pulse lags the pointer by 1 cycle.
// No backpressure; a multi-token jump in rptr_in is paid out as back-to-back pulses.
module bsg_down_token_gen #(
  parameter int PTR_W    = 7,
  parameter int DECIMATE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PTR_W-1:0] rptr_in,
  output logic             token_out
);

  localparam logic [PTR_W-1:0] DEC = PTR_W'(DECIMATE);

  logic [PTR_W-1:0] rptr_seen;
  logic [PTR_W-1:0] pending;

  // Modulo subtraction keeps the distance correct across the pointer wrap.
  assign pending = rptr_in - rptr_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_seen <= '0;
      token_out <= 1'b0;
    end else if (pending >= DEC) begin
      rptr_seen <= rptr_seen + DEC;
      token_out <= 1'b1;
    end else begin
      token_out <= 1'b0;
    end
  end

endmodule

// File: rtl/bsg_down_io_pack.sv
// Io-side write stage: packs byte pairs into entries and writes them the cycle the 2nd byte lands;
// wptr_t publishes one cycle later. No backpressure to io: entries arriving while full are dropped.
module bsg_down_io_pack #(
  parameter int BYTE_W         = 8,
  parameter int ENTRY_W        = 16,
  parameter int ADDR_W         = 6,
  parameter int TOKEN_DECIMATE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               io_valid_in,
  input  logic [BYTE_W-1:0]  io_data_in,
  input  logic [ADDR_W:0]    rptr_in,
  output logic               buf_we,
  output logic [ADDR_W-1:0]  buf_waddr,
  output logic [ENTRY_W-1:0] buf_wdata,
  output logic [ADDR_W:0]    wptr,
  output logic [ADDR_W:0]    wptr_t,
  output logic               full,
  output logic               io_token_out,
  output logic               overflow_err
);

  import bsg_down_pkg::*;

  pack_state_e       state_q, state_d;
  logic [BYTE_W-1:0] lo_q, lo_d;
  logic              entry_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LO;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    entry_done = 1'b0;
    case (state_q)
      LO: begin
        if (io_valid_in) begin
          lo_d    = io_data_in;
          state_d = HI;
        end
      end
      HI: begin
        if (io_valid_in) begin
          entry_done = 1'b1;
          state_d    = LO;
        end
      end
      default: state_d = LO;
    endcase
  end

  // Full looks only at the current wptr, so a consumer advance this cycle cannot save the entry.
  assign full      = ptr_full(wptr, rptr_in) & ~rst;
  assign buf_we    = entry_done & ~full & ~rst;
  assign buf_waddr = wptr[ADDR_W-1:0];
  assign buf_wdata = {io_data_in, lo_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      wptr_t       <= '0;
      overflow_err <= 1'b0;
    end else begin
      wptr_t <= wptr;
      if (buf_we)
        wptr <= wptr + 1'b1;
      if (entry_done && full)
        overflow_err <= 1'b1;
    end
  end

  bsg_down_token_gen #(
    .PTR_W    (ADDR_W + 1),
    .DECIMATE (TOKEN_DECIMATE)
  ) u_token_gen (
    .clk       (clk),
    .rst       (rst),
    .rptr_in   (rptr_in),
    .token_out (io_token_out)
  );

endmodule

// File: tb/tb_bsg_down_io_pack.sv
// Directed bench for bsg_down_io_pack: packing, gaps, full/overflow, tokens, wrap, mid-entry reset.
module tb_bsg_down_io_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_valid_in;
  logic [7:0]  io_data_in;
  logic [6:0]  rptr_in;
  logic        buf_we;
  logic [5:0]  buf_waddr;
  logic [15:0] buf_wdata;
  logic [6:0]  wptr;
  logic [6:0]  wptr_t;
  logic        full;
  logic        io_token_out;
  logic        overflow_err;

  int checks   = 0;
  int failures = 0;

  int we_cnt  = 0;
  int tok_cnt = 0;
  int base_we, base_tok;

  logic       wrap_mon = 1'b0;
  logic [5:0] exp_addr = '0;
  int         full_cnt = 0;
  logic       saw_127  = 1'b0;
  logic       wrapped  = 1'b0;

  always #5 clk = ~clk;

  bsg_down_io_pack dut (
    .clk          (clk),
    .rst          (rst),
    .io_valid_in  (io_valid_in),
    .io_data_in   (io_data_in),
    .rptr_in      (rptr_in),
    .buf_we       (buf_we),
    .buf_waddr    (buf_waddr),
    .buf_wdata    (buf_wdata),
    .wptr         (wptr),
    .wptr_t       (wptr_t),
    .full         (full),
    .io_token_out (io_token_out),
    .overflow_err (overflow_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All stimulus changes land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    io_valid_in = 1'b0;
    io_data_in  = '0;
    rptr_in     = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Mid-cycle monitor for write/token counts and the wrap-phase address sequence.
  always @(negedge clk) begin
    if (buf_we) begin
      we_cnt++;
      if (wrap_mon) begin
        check("wrap_waddr", 32'(buf_waddr), 32'(exp_addr));
        exp_addr <= exp_addr + 6'd1;
      end
    end
    if (io_token_out)
      tok_cnt++;
    if (wrap_mon) begin
      if (full) full_cnt++;
      if (wptr == 7'd127) saw_127 <= 1'b1;
      if (saw_127 && wptr == 7'd0) wrapped <= 1'b1;
    end
  end

  initial begin
    int  sent;
    logic done;

    // Reset state
    do_reset();
    #2;
    check("rst_wptr",    32'(wptr),         32'h0);
    check("rst_wptr_t",  32'(wptr_t),       32'h0);
    check("rst_full",    32'(full),         32'h0);
    check("rst_we",      32'(buf_we),       32'h0);
    check("rst_token",   32'(io_token_out), 32'h0);
    check("rst_ovf",     32'(overflow_err), 32'h0);
    tick();

    // Back-to-back pair 0x34, 0x12
    io_valid_in = 1'b1;
    io_data_in  = 8'h34;
    #2;
    check("t1_no_we_lo", 32'(buf_we), 32'h0);
    tick();
    io_data_in = 8'h12;
    #2;
    check("t1_we",    32'(buf_we),    32'h1);
    check("t1_waddr", 32'(buf_waddr), 32'h0);
    check("t1_wdata", 32'(buf_wdata), 32'h1234);
    tick();
    io_valid_in = 1'b0;
    check("t1_wptr",     32'(wptr),   32'h1);
    check("t1_wptr_t_0", 32'(wptr_t), 32'h0);
    tick();
    check("t1_wptr_t_1", 32'(wptr_t), 32'h1);

    // Pair with idle gap
    base_we     = we_cnt;
    io_valid_in = 1'b1;
    io_data_in  = 8'hAA;
    tick();
    io_valid_in = 1'b0;
    io_data_in  = 8'h00;
    tick();
    tick();
    tick();
    check("t2_lo_hold", 32'(dut.lo_q),    32'hAA);
    check("t2_state",   32'(dut.state_q), 32'h1);
    io_valid_in = 1'b1;
    io_data_in  = 8'hBB;
    #2;
    check("t2_we",    32'(buf_we),    32'h1);
    check("t2_wdata", 32'(buf_wdata), 32'hBBAA);
    check("t2_waddr", 32'(buf_waddr), 32'h1);
    tick();
    io_valid_in = 1'b0;
    check("t2_nwrites", 32'(we_cnt - base_we), 32'h1);
    check("t2_wptr",    32'(wptr),             32'h2);

    // Fill to full, then overflow
    do_reset();
    base_we = we_cnt;
    for (int i = 0; i < 128; i++) begin
      io_valid_in = 1'b1;
      io_data_in  = 8'(i);
      if (i == 127) begin
        #2;
        check("t3_full_not_yet", 32'(full), 32'h0);
      end
      tick();
    end
    io_valid_in = 1'b0;
    #2;
    check("t3_nwrites", 32'(we_cnt - base_we), 32'd64);
    check("t3_wptr",    32'(wptr),             32'h40);
    check("t3_full",    32'(full),             32'h1);
    check("t3_ovf_pre", 32'(overflow_err),     32'h0);
    tick();
    io_valid_in = 1'b1;
    io_data_in  = 8'hEE;
    tick();
    io_data_in = 8'hEF;
    #2;
    check("t3_drop_we", 32'(buf_we), 32'h0);
    tick();
    io_valid_in = 1'b0;
    check("t3_ovf",      32'(overflow_err),     32'h1);
    check("t3_wptr_hld", 32'(wptr),             32'h40);
    check("t3_state_lo", 32'(dut.state_q),      32'h0);
    check("t3_nwr_hold", 32'(we_cnt - base_we), 32'd64);
    rptr_in = 7'd1;
    #2;
    check("t3_full_fall", 32'(full), 32'h0);
    tick();
    check("t3_ovf_sticky", 32'(overflow_err), 32'h1);

    // Token burst: rptr_in jumps 0 -> 8
    do_reset();
    for (int i = 0; i < 16; i++) begin
      io_valid_in = 1'b1;
      io_data_in  = 8'(i + 8'h40);
      tick();
    end
    io_valid_in = 1'b0;
    tick();
    base_tok = tok_cnt;
    check("t4_no_tok_fill", 32'(tok_cnt), 32'(base_tok));
    rptr_in = 7'd8;
    #2;
    check("t4_tok_c0", 32'(io_token_out), 32'h0);
    tick();
    check("t4_tok_c1", 32'(io_token_out), 32'h1);
    tick();
    check("t4_tok_c2", 32'(io_token_out), 32'h1);
    tick();
    check("t4_tok_c3",  32'(io_token_out),          32'h0);
    check("t4_seen",    32'(dut.u_token_gen.rptr_seen), 32'h8);
    check("t4_ntokens", 32'(tok_cnt - base_tok),   32'h2);

    // Wrap: 200 entries streamed through with a draining consumer
    do_reset();
    base_we  = we_cnt;
    base_tok = tok_cnt;
    wrap_mon = 1'b1;
    sent     = 0;
    done     = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      if (sent < 400) begin
        io_valid_in = 1'b1;
        io_data_in  = 8'(sent);
        sent++;
      end else begin
        io_valid_in = 1'b0;
      end
      if (rptr_in != wptr_t)
        rptr_in = rptr_in + 7'd1;
      done = (sent == 400) && (rptr_in == wptr_t) && (wptr_t == wptr) && !io_valid_in;
      tick();
    end
    io_valid_in = 1'b0;
    tick();
    tick();
    tick();
    wrap_mon = 1'b0;
    check("t5_done",     32'(done),                32'h1);
    check("t5_nwrites",  32'(we_cnt - base_we),    32'd200);
    check("t5_wptr",     32'(wptr),                32'd72);
    check("t5_wrapped",  32'(wrapped),             32'h1);
    check("t5_no_full",  32'(full_cnt),            32'h0);
    check("t5_no_ovf",   32'(overflow_err),        32'h0);
    check("t5_ntokens",  32'(tok_cnt - base_tok),  32'd50);

    // Reset arriving mid-entry
    io_valid_in = 1'b1;
    io_data_in  = 8'h55;
    tick();
    check("t6_half", 32'(dut.lo_q), 32'h55);
    rst         = 1'b1;
    rptr_in     = '0;
    io_data_in  = 8'h66;
    #2;
    check("t6_no_we_rst", 32'(buf_we), 32'h0);
    tick();
    rst     = 1'b0;
    base_we = we_cnt;
    io_data_in = 8'h01;
    #2;
    check("t6_lo_clr",  32'(dut.lo_q),    32'h0);
    check("t6_state",   32'(dut.state_q), 32'h0);
    check("t6_no_we_1", 32'(buf_we),      32'h0);
    tick();
    io_data_in = 8'h02;
    #2;
    check("t6_we",    32'(buf_we),    32'h1);
    check("t6_wdata", 32'(buf_wdata), 32'h0201);
    check("t6_waddr", 32'(buf_waddr), 32'h0);
    tick();
    io_valid_in = 1'b0;
    check("t6_nwrites", 32'(we_cnt - base_we), 32'h1);
    check("t6_wptr",    32'(wptr),             32'h1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_down_io_pack.md
# bsg_down_io_pack

Io-side write stage of the downstream channel. Accepts the 8-bit io byte stream, packs byte pairs into 16-bit buffer entries, and writes them into the 64-entry channel buffer. It owns the write pointers (`wptr`, `wptr_t`) and the full flag that the core-side output stage compares against its read pointer. It returns flow-control tokens to the io transmitter as entries are drained.

## Interface
Parameters:
- `BYTE_W`, 8, io byte width.
- `ENTRY_W`, 16, buffer entry width; always 2×`BYTE_W`.
- `ADDR_W`, 6, buffer address width (64 entries); pointers are `ADDR_W+1` bits.
- `TOKEN_DECIMATE`, 4, entries drained per returned token; power of two, ≥1, ≤32.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `io_valid_in`  in  1  byte strobe; one byte per asserted cycle.
- `io_data_in`  in  8  io byte.
- `rptr_in`  in  7  consumer read pointer in the `clk` domain; monotonic mod 128.
- `buf_we`  out  1  buffer write enable.
- `buf_waddr`  out  6  write address = `wptr[5:0]`.
- `buf_wdata`  out  16  `{hi_byte, lo_byte}`.
- `wptr`  out  7  internal write pointer.
- `wptr_t`  out  7  published write pointer; the consumer reads only while `wptr_t != rptr`.
- `full`  out  1  buffer full.
- `io_token_out`  out  1  one-cycle credit pulse to the transmitter.
- `overflow_err`  out  1  sticky; an entry was dropped because the buffer was full.

## Operation
- Byte packing uses a 2-state FSM.
  - `LO` (reset state): on `io_valid_in`, capture `io_data_in` into `lo_q` and move to `HI`.
  - `HI`: on `io_valid_in`, the entry is complete. Drive `buf_wdata = {io_data_in, lo_q}` combinationally and return to `LO`.
  - With no `io_valid_in`, the FSM holds its state and `lo_q`.
- Commit:
  - When an entry completes and `full==0`: `buf_we=1`, `buf_waddr=wptr[5:0]`, and `wptr` increments by 1 (7-bit wrap 127→0).
  - When an entry completes and `full==1`: `buf_we=0`, the entry is dropped, and `overflow_err` is set until reset. The FSM still returns to `LO`.
- Full flag: `full = (wptr[5:0]==rptr_in[5:0]) && (wptr[6]!=rptr_in[6])`. It is combinational on the current `wptr`, so a same-cycle consumer advance does not rescue an entry.
- Publication: `wptr_t <= wptr` every cycle. Data is therefore written into the buffer one cycle before the consumer can observe it.
- Tokens:
  - Register `rptr_seen` (7 bits, reset 0).
  - Compute `pending = rptr_in - rptr_seen` mod 128.
  - If `pending >= TOKEN_DECIMATE`: pulse `io_token_out` for one cycle and advance `rptr_seen` by `TOKEN_DECIMATE`.
  - At most one pulse per cycle; a burst of drained entries produces back-to-back pulses.
- Reset values: `wptr`, `wptr_t`, `rptr_seen` = 0; FSM = `LO`; `lo_q` = 0; `full`, `buf_we`, `io_token_out`, `overflow_err` = 0.
- Reset mid-entry discards a half-packed byte. No write occurs in the reset cycle.
- `rptr_in` must also be 0 out of reset.

## Timing
- Latency from the second byte to the buffer write is 0 cycles (same cycle as `io_valid_in`). The write becomes visible on `wptr_t` 1 cycle later.
- Sustained throughput is one entry per 2 valid bytes. Back-to-back `io_valid_in` is legal indefinitely.
- `full` rises in the cycle after the 64th unconsumed commit. It falls in the same cycle `rptr_in` advances.
- `io_token_out` asserts 1 cycle after `rptr_in` makes `pending` reach `TOKEN_DECIMATE`.
- Pointer wrap: all pointer arithmetic is 7-bit modulo. The wrap bit distinguishes full from empty at equal low bits.

## Structure
- Shared package `bsg_down_pkg`:
  - `BYTE_W`, `ENTRY_W`, `ADDR_W`, `PTR_W=ADDR_W+1`.
  - typedefs `ptr_t`, `entry_t`.
  - enum `pack_state_e {LO, HI}`.
  - function `ptr_full(ptr_t w, ptr_t r)`.
- One sub-module: `bsg_down_token_gen`, containing the `rptr_seen`/`pending` comparator and pulse logic. It is reusable by the upstream channel.
- The buffer RAM lives outside this block.

## Test plan
- Reset, then bytes 0x34, 0x12 on consecutive cycles → `buf_we` in cycle 2 with `buf_waddr=0`, `buf_wdata=0x1234`; `wptr=1` next cycle; `wptr_t=1` one cycle later.
- Bytes with gaps (0xAA, idle×3, 0xBB) → single write of 0xBBAA; `lo_q` holds across the idle cycles.
- 128 bytes with `rptr_in=0` → 64 writes, `full=1`, `wptr=0x40`. The next 2 bytes produce no write and `overflow_err=1`. Then `rptr_in=1` → `full=0`.
- Drain with `rptr_in` stepping 0→8 in one cycle, `TOKEN_DECIMATE=4` → exactly 2 `io_token_out` pulses on consecutive cycles; `rptr_seen=8`.
- Wrap: fill and drain 200 entries with the consumer model, then `wptr` 127→0 → addresses wrap 63→0 with no spurious `full` or overflow; token count = 50.
- Assert `rst` after the first byte (0x55) of a pair, then send 0x01, 0x02 → write 0x0201 at address 0; 0x55 is never written.
